// File: rtl/key_filter_multi.sv
// key_filter_multi
//   N-channel push-button conditioner. Each channel synchronises its raw pad
//   input, debounces both press and release, and reports a stable level plus
//   one-cycle press, release, long-press and auto-repeat event pulses.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   key_in        raw key pins (pressed = 0 when ACTIVE_LOW = 1, else 1)
//   key_level     debounced level, 1 = pressed
//   press_flag    1-cycle pulse on confirmed press
//   release_flag  1-cycle pulse on confirmed release
//   long_flag     1-cycle pulse once per press when the hold reaches the long time
//   repeat_flag   1-cycle periodic pulses after long_flag while still held
//
// Per-channel states
//   state        | meaning
//   ST_IDLE      | stable released
//   ST_PRESS_DEB | press seen, waiting for it to stay stable
//   ST_PRESSED   | stable pressed, hold / repeat timing runs
//   ST_REL_DEB   | release seen, waiting for it to stay stable
module key_filter_multi #(
  parameter int KEY_NUM      = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int CNT_DEB_MAX  = 999_999,
  parameter int CNT_LONG_MAX = 49_999_999,
  parameter int CNT_REP_MAX  = 9_999_999,
  parameter int REPEAT_EN    = 1,
  parameter int CNT_W        = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] press_flag,
  output logic [KEY_NUM-1:0] release_flag,
  output logic [KEY_NUM-1:0] long_flag,
  output logic [KEY_NUM-1:0] repeat_flag
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_REL_DEB   = 2'd3;

  localparam logic PH_HOLD   = 1'b0;
  localparam logic PH_REPEAT = 1'b1;

  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(CNT_DEB_MAX);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(CNT_LONG_MAX);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(CNT_REP_MAX);

  // Synchroniser flops idle at the released pad level so leaving reset never
  // looks like a press.
  localparam logic PAD_RELEASED = (ACTIVE_LOW != 0);
  localparam logic REP_ENABLE   = (REPEAT_EN != 0);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic             sync1, sync2;
    logic             s;
    logic [1:0]       state;
    logic             phase;
    logic [CNT_W-1:0] deb_cnt, hold_cnt, rep_cnt;
    logic             level_q, press_q, rel_q, long_q, rep_q;

    logic [CNT_W-1:0] hold_nxt, rep_nxt;
    logic             phase_nxt, long_evt, rep_evt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= PAD_RELEASED;
        sync2 <= PAD_RELEASED;
      end else begin
        sync1 <= key_in[i];
        sync2 <= sync1;
      end
    end

    assign s = PAD_RELEASED ? ~sync2 : sync2;

    // One step of the hold/repeat timers. Used both while staying pressed and
    // on the edge that returns from a rejected release glitch, so the long
    // press slips by exactly the cycles spent in ST_REL_DEB.
    always_comb begin
      hold_nxt  = hold_cnt;
      rep_nxt   = rep_cnt;
      phase_nxt = phase;
      long_evt  = 1'b0;
      rep_evt   = 1'b0;
      if (phase == PH_HOLD) begin
        if (hold_cnt == LONG_TC) begin
          long_evt  = 1'b1;
          phase_nxt = PH_REPEAT;
          rep_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end else begin
        if (rep_cnt == REP_TC) begin
          rep_evt = REP_ENABLE;
          rep_nxt = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        phase    <= PH_HOLD;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        level_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (s) begin
              state   <= ST_PRESS_DEB;
              deb_cnt <= '0;
            end
          end
          ST_PRESS_DEB: begin
            if (!s) begin
              state   <= ST_IDLE;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_TC) begin
              state    <= ST_PRESSED;
              press_q  <= 1'b1;
              level_q  <= 1'b1;
              deb_cnt  <= '0;
              hold_cnt <= '0;
              rep_cnt  <= '0;
              phase    <= PH_HOLD;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          ST_PRESSED: begin
            // Release detection wins: timers freeze on this edge.
            if (!s) begin
              state   <= ST_REL_DEB;
              deb_cnt <= '0;
            end else begin
              hold_cnt <= hold_nxt;
              rep_cnt  <= rep_nxt;
              phase    <= phase_nxt;
              long_q   <= long_evt;
              rep_q    <= rep_evt;
            end
          end
          default: begin // ST_REL_DEB
            if (s) begin
              state    <= ST_PRESSED;
              hold_cnt <= hold_nxt;
              rep_cnt  <= rep_nxt;
              phase    <= phase_nxt;
              long_q   <= long_evt;
              rep_q    <= rep_evt;
            end else if (deb_cnt == DEB_TC) begin
              state    <= ST_IDLE;
              rel_q    <= 1'b1;
              level_q  <= 1'b0;
              deb_cnt  <= '0;
              hold_cnt <= '0;
              rep_cnt  <= '0;
              phase    <= PH_HOLD;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
        endcase
      end
    end

    assign key_level[i]    = level_q;
    assign press_flag[i]   = press_q;
    assign release_flag[i] = rel_q;
    assign long_flag[i]    = long_q;
    assign repeat_flag[i]  = rep_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
module tb_key_filter_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;

  logic [3:0] key_level, press_flag, release_flag, long_flag, repeat_flag;
  logic [3:0] b_level, b_press, b_release, b_long, b_repeat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_filter_multi #(
    .KEY_NUM(4), .ACTIVE_LOW(1), .CNT_DEB_MAX(9), .CNT_LONG_MAX(49),
    .CNT_REP_MAX(19), .REPEAT_EN(1), .CNT_W(26)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .press_flag(press_flag), .release_flag(release_flag),
    .long_flag(long_flag), .repeat_flag(repeat_flag)
  );

  key_filter_multi #(
    .KEY_NUM(4), .ACTIVE_LOW(1), .CNT_DEB_MAX(9), .CNT_LONG_MAX(49),
    .CNT_REP_MAX(19), .REPEAT_EN(0), .CNT_W(26)
  ) dut_norep (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(b_level), .press_flag(b_press), .release_flag(b_release),
    .long_flag(b_long), .repeat_flag(b_repeat)
  );

  task automatic chk(input string name, input int e, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %b expected %b", name, e, got, exp);
    end
  endtask

  // Compare both instances; the REPEAT_EN=0 copy must match except repeat=0.
  task automatic cmp(input string tag, input int e, input logic [3:0] ep,
                     input logic [3:0] er, input logic [3:0] el,
                     input logic [3:0] erp, input logic [3:0] elv);
    chk({tag, ".press"},   e, press_flag,   ep);
    chk({tag, ".release"}, e, release_flag, er);
    chk({tag, ".long"},    e, long_flag,    el);
    chk({tag, ".repeat"},  e, repeat_flag,  erp);
    chk({tag, ".level"},   e, key_level,    elv);
    chk({tag, ".nr.press"},   e, b_press,   ep);
    chk({tag, ".nr.release"}, e, b_release, er);
    chk({tag, ".nr.long"},    e, b_long,    el);
    chk({tag, ".nr.repeat"},  e, b_repeat,  4'b0000);
    chk({tag, ".nr.level"},   e, b_level,   elv);
  endtask

  task automatic tick(input string tag, input int e, input logic [3:0] ep,
                      input logic [3:0] er, input logic [3:0] el,
                      input logic [3:0] erp, input logic [3:0] elv);
    @(posedge clk);
    #1;
    cmp(tag, e, ep, er, el, erp, elv);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    key_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ep, er, el, erp, elv;

    // Reset state
    rst_n  = 1'b0;
    key_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", 0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    do_reset();

    // 1: clean press on ch0, low edges 1..30
    for (int e = 1; e <= 50; e++) begin
      key_in = (e <= 30) ? 4'b1110 : 4'b1111;
      ep  = (e == 13) ? 4'b0001 : 4'b0000;
      er  = (e == 43) ? 4'b0001 : 4'b0000;
      elv = (e >= 13 && e < 43) ? 4'b0001 : 4'b0000;
      tick("clean", e, ep, er, 4'b0, 4'b0, elv);
    end

    // 2: bounce on ch1, 5 low / 3 high x4
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      key_in = (e <= 32 && ((e - 1) % 8) < 5) ? 4'b1101 : 4'b1111;
      tick("bounce", e, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // 3: long hold on ch2, low edges 1..190
    do_reset();
    for (int e = 1; e <= 210; e++) begin
      key_in = (e <= 190) ? 4'b1011 : 4'b1111;
      ep  = (e == 13)  ? 4'b0100 : 4'b0000;
      el  = (e == 63)  ? 4'b0100 : 4'b0000;
      er  = (e == 203) ? 4'b0100 : 4'b0000;
      erp = (e >= 83 && e <= 183 && ((e - 83) % 20) == 0) ? 4'b0100 : 4'b0000;
      elv = (e >= 13 && e < 203) ? 4'b0100 : 4'b0000;
      tick("long", e, ep, er, el, erp, elv);
    end

    // 4: release glitch on ch0, high on edges 21..24; long slips 63 -> 67
    do_reset();
    for (int e = 1; e <= 90; e++) begin
      key_in = ((e <= 20) || (e >= 25 && e <= 70)) ? 4'b1110 : 4'b1111;
      ep  = (e == 13) ? 4'b0001 : 4'b0000;
      el  = (e == 67) ? 4'b0001 : 4'b0000;
      er  = (e == 83) ? 4'b0001 : 4'b0000;
      elv = (e >= 13 && e < 83) ? 4'b0001 : 4'b0000;
      tick("glitch", e, ep, er, el, 4'b0, elv);
    end

    // 5: ch0 and ch3 simultaneous, low edges 1..20
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      key_in = (e <= 20) ? 4'b0110 : 4'b1111;
      ep  = (e == 13) ? 4'b1001 : 4'b0000;
      er  = (e == 33) ? 4'b1001 : 4'b0000;
      elv = (e >= 13 && e < 33) ? 4'b1001 : 4'b0000;
      tick("simul", e, ep, er, 4'b0, 4'b0, elv);
    end

    // 6a: reset during REPEAT, key released during reset
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      key_in = 4'b1011;
      ep  = (e == 13) ? 4'b0100 : 4'b0000;
      el  = (e == 63) ? 4'b0100 : 4'b0000;
      elv = (e >= 13) ? 4'b0100 : 4'b0000;
      tick("prerst", e, ep, 4'b0, el, 4'b0, elv);
    end
    rst_n  = 1'b0;
    key_in = 4'hF;
    #1;
    cmp("rst_async", 0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    for (int e = 1; e <= 5; e++) tick("in_rst", e, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) tick("post_rst", e, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // 6b: key held through reset is debounced afresh
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      key_in = 4'b1011;
      ep  = (e == 13) ? 4'b0100 : 4'b0000;
      elv = (e >= 13) ? 4'b0100 : 4'b0000;
      tick("held_pre", e, ep, 4'b0, 4'b0, 4'b0, elv);
    end
    rst_n = 1'b0;
    #1;
    cmp("held_async", 0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    for (int e = 1; e <= 3; e++) tick("held_rst", e, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      ep  = (e == 13) ? 4'b0100 : 4'b0000;
      elv = (e >= 13) ? 4'b0100 : 4'b0000;
      tick("held_post", e, ep, 4'b0, 4'b0, 4'b0, elv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
